// File: rtl/id_pipe_stage.sv
// RV32I instruction-decode stage: bypassed register file, load-use hazard detection,
// immediate / branch-target generation and a registered ID/EX handshake register.
module id_pipe_stage #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [AW-1:0]   ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [10:0]     out_controls,
    output logic            out_reg_write,
    output logic [1:0]      out_inst_size,
    output logic [XLEN-1:0] out_reg_a,
    output logic [XLEN-1:0] out_reg_b,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_branch_addr,
    output logic [XLEN-1:0] out_pc,
    output logic [AW-1:0]   out_rd,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [15:0]     stall_count
);

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] inst);
        logic [31:0] imm32;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: imm32 = {{20{inst[31]}}, inst[31:20]};
            7'b0100011: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm32 = {inst[31:12], 12'd0};
            7'b1101111: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        return XLEN'(signed'(imm32));
    endfunction

    // Packed as {mem_read, mem_write, alu_src, mem_to_reg[1:0], jump[1:0], alu_op[3:0], reg_write, inst_size[1:0]}
    function automatic logic [13:0] decode_ctrl(input logic [31:0] inst);
        logic       mr, mw, asrc, rw;
        logic [1:0] m2r, jmp, isz;
        logic [3:0] aop;
        mr = 1'b0; mw = 1'b0; asrc = 1'b0; rw = 1'b0;
        m2r = 2'b00; jmp = 2'b00; isz = 2'b10; aop = 4'b0000;
        case (inst[6:0])
            7'b0110011: begin rw = 1'b1; aop = {inst[30], inst[14:12]}; end
            7'b0010011: begin
                rw = 1'b1; asrc = 1'b1;
                aop = {(inst[14:12] == 3'b101) & inst[30], inst[14:12]};
            end
            7'b0000011: begin rw = 1'b1; asrc = 1'b1; mr = 1'b1; m2r = 2'b01; isz = inst[13:12]; end
            7'b0100011: begin mw = 1'b1; asrc = 1'b1; isz = inst[13:12]; end
            7'b1100011: begin jmp = 2'b01; aop = 4'b1000; end
            7'b1101111: begin rw = 1'b1; jmp = 2'b10; m2r = 2'b10; end
            7'b1100111: begin rw = 1'b1; asrc = 1'b1; jmp = 2'b11; m2r = 2'b10; end
            7'b0110111: begin rw = 1'b1; asrc = 1'b1; aop = 4'b1111; end
            7'b0010111: begin rw = 1'b1; asrc = 1'b1; end
            default:    begin isz = 2'b00; end
        endcase
        return {mr, mw, asrc, m2r, jmp, aop, rw, isz};
    endfunction

    logic [XLEN-1:0] rf_r [NREGS];
    logic [AW-1:0]   rd_s, rs1_s, rs2_s;
    logic [XLEN-1:0] op_a_s, op_b_s, imm_s;
    logic [13:0]     ctrl_s;
    logic            hazard_s, load_en_s, in_ready_s, accept_s;

    logic            out_valid_r, out_reg_write_r;
    logic [10:0]     out_controls_r;
    logic [1:0]      out_inst_size_r;
    logic [XLEN-1:0] out_reg_a_r, out_reg_b_r, out_imm_r, out_branch_addr_r, out_pc_r;
    logic [AW-1:0]   out_rd_r, out_rs1_r, out_rs2_r;
    logic [15:0]     stall_count_r;

    assign rd_s   = in_inst[7 +: AW];
    assign rs1_s  = in_inst[15 +: AW];
    assign rs2_s  = in_inst[20 +: AW];
    assign imm_s  = gen_imm(in_inst);
    assign ctrl_s = decode_ctrl(in_inst);

    // Operand read with same-cycle write-back bypass; x0 is hard-wired to zero.
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        op_b_s = {XLEN{1'b0}};
        if (rs1_s == {AW{1'b0}}) begin
            op_a_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == rs1_s)) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = rf_r[rs1_s];
        end
        if (rs2_s == {AW{1'b0}}) begin
            op_b_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == rs2_s)) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = rf_r[rs2_s];
        end
    end

    // Load-use hazard and IF/ID handshake; in_ready is held low while reset is asserted.
    always_comb begin
        hazard_s   = in_valid && ex_mem_read && (ex_rd != {AW{1'b0}}) &&
                     ((ex_rd == rs1_s) || (ex_rd == rs2_s));
        load_en_s  = !out_valid_r || out_ready;
        in_ready_s = reset && load_en_s && !hazard_s && !flush;
        accept_s   = in_valid && in_ready_s;
    end

    // Register file storage; writes to x0 are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en && (wb_addr != {AW{1'b0}})) begin
            rf_r[wb_addr] <= wb_data;
        end else begin
            rf_r[0] <= {XLEN{1'b0}};
        end
    end

    // ID/EX pipeline register: flush beats load, bubbles keep the old payload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r       <= 1'b0;
            out_controls_r    <= 11'd0;
            out_reg_write_r   <= 1'b0;
            out_inst_size_r   <= 2'd0;
            out_reg_a_r       <= {XLEN{1'b0}};
            out_reg_b_r       <= {XLEN{1'b0}};
            out_imm_r         <= {XLEN{1'b0}};
            out_branch_addr_r <= {XLEN{1'b0}};
            out_pc_r          <= {XLEN{1'b0}};
            out_rd_r          <= {AW{1'b0}};
            out_rs1_r         <= {AW{1'b0}};
            out_rs2_r         <= {AW{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_en_s) begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_controls_r    <= ctrl_s[13:3];
                out_reg_write_r   <= ctrl_s[2];
                out_inst_size_r   <= ctrl_s[1:0];
                out_reg_a_r       <= op_a_s;
                out_reg_b_r       <= op_b_s;
                out_imm_r         <= imm_s;
                out_branch_addr_r <= in_pc + imm_s;
                out_pc_r          <= in_pc;
                out_rd_r          <= rd_s;
                out_rs1_r         <= rs1_s;
                out_rs2_r         <= rs2_s;
            end
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 16'd0;
        end else if (hazard_s && !flush && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign out_controls    = out_controls_r;
    assign out_reg_write   = out_reg_write_r;
    assign out_inst_size   = out_inst_size_r;
    assign out_reg_a       = out_reg_a_r;
    assign out_reg_b       = out_reg_b_r;
    assign out_imm         = out_imm_r;
    assign out_branch_addr = out_branch_addr_r;
    assign out_pc          = out_pc_r;
    assign out_rd          = out_rd_r;
    assign out_rs1         = out_rs1_r;
    assign out_rs2         = out_rs2_r;
    assign stall_count     = stall_count_r;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: vector table plus scoreboard queue and
// hand-written sequences for bypass, load-use, backpressure/flush, reset and saturation.
module tb_id_pipe_stage;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [10:0] out_controls;
    logic        out_reg_write;
    logic [1:0]  out_inst_size;
    logic [31:0] out_reg_a, out_reg_b, out_imm, out_branch_addr, out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [15:0] stall_count;

    id_pipe_stage #(.XLEN(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_controls(out_controls), .out_reg_write(out_reg_write), .out_inst_size(out_inst_size),
        .out_reg_a(out_reg_a), .out_reg_b(out_reg_b), .out_imm(out_imm),
        .out_branch_addr(out_branch_addr), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        rw;
    } vec_t;

    typedef struct {
        logic [31:0] pc, imm, br, a, b;
        logic [4:0]  rd, rs1, rs2;
        logic        rw, mr, mw;
    } rec_t;

    rec_t        sbq[$];
    logic [31:0] m_rf [32];
    logic        mv;
    logic [15:0] m_cnt;
    logic [31:0] cur_imm;
    logic        cur_rw;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] s0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    task automatic model_reset();
        mv = 1'b0;
        m_cnt = 16'd0;
        sbq.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] imm, input logic rw);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        cur_imm  = imm;
        cur_rw   = rw;
    endtask

    // One clock: check at negedge against the model, then advance model state for the edge.
    task automatic tick();
        rec_t e;
        logic hz, le, er, acc;
        @(negedge clock);
        hz = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
             (ex_rd == in_inst[19:15] || ex_rd == in_inst[24:20]);
        le = !mv || out_ready;
        er = reset && le && !hz && !flush;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        if (mv) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
            end else begin
                chk("out_pc", out_pc, sbq[0].pc);
                chk("out_imm", out_imm, sbq[0].imm);
                chk("out_branch_addr", out_branch_addr, sbq[0].br);
                chk("out_reg_a", out_reg_a, sbq[0].a);
                chk("out_reg_b", out_reg_b, sbq[0].b);
                chk("out_rd", 32'(out_rd), 32'(sbq[0].rd));
                chk("out_rs1", 32'(out_rs1), 32'(sbq[0].rs1));
                chk("out_rs2", 32'(out_rs2), 32'(sbq[0].rs2));
                chk("out_reg_write", 32'(out_reg_write), 32'(sbq[0].rw));
                chk("out_mem_read", 32'(out_controls[10]), 32'(sbq[0].mr));
                chk("out_mem_write", 32'(out_controls[9]), 32'(sbq[0].mw));
            end
        end
        acc = in_valid && er;
        e.pc  = in_pc;
        e.imm = cur_imm;
        e.br  = in_pc + cur_imm;
        e.a   = rd_model(in_inst[19:15]);
        e.b   = rd_model(in_inst[24:20]);
        e.rd  = in_inst[11:7];
        e.rs1 = in_inst[19:15];
        e.rs2 = in_inst[24:20];
        e.rw  = cur_rw;
        e.mr  = (in_inst[6:0] == 7'b0000011);
        e.mw  = (in_inst[6:0] == 7'b0100011);
        if (reset) begin
            if (hz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (flush) begin
                if (mv && sbq.size() > 0) void'(sbq.pop_front());
                mv = 1'b0;
            end else if (le) begin
                if (mv && sbq.size() > 0) void'(sbq.pop_front());
                mv = acc;
                if (acc) sbq.push_back(e);
            end
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        end
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h000180B3, 32'h00000000, 32'h00000000, 1'b1}; // add x1,x3,x0
        vecs[1]  = '{32'hFFF00293, 32'h00000004, 32'hFFFFFFFF, 1'b1}; // addi x5,x0,-1
        vecs[2]  = '{32'h00812303, 32'h00000008, 32'h00000008, 1'b1}; // lw x6,8(x2)
        vecs[3]  = '{32'h00512623, 32'h0000000C, 32'h0000000C, 1'b0}; // sw x5,12(x2)
        vecs[4]  = '{32'hFE000EE3, 32'h00000100, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[5]  = '{32'h0080006F, 32'h00000104, 32'h00000008, 1'b1}; // jal x0,8
        vecs[6]  = '{32'h123453B7, 32'h00000108, 32'h12345000, 1'b1}; // lui x7,0x12345
        vecs[7]  = '{32'h80000417, 32'h00000200, 32'h80000000, 1'b1}; // auipc x8,0x80000
        vecs[8]  = '{32'hFF0280E7, 32'h00000204, 32'hFFFFFFF0, 1'b1}; // jalr x1,-16(x5)
        vecs[9]  = '{32'hFFFFFFFF, 32'h00000300, 32'h00000000, 1'b0}; // unknown opcode
        vecs[10] = '{32'h00209863, 32'hFFFFFFF8, 32'h00000010, 1'b0}; // bne x1,x2,+16 (wraps)
        vecs[11] = '{32'hFE112E23, 32'h00000400, 32'hFFFFFFFC, 1'b0}; // sw x1,-4(x2)

        reset = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        flush = 1'b0; out_ready = 1'b1; cur_imm = 32'd0; cur_rw = 1'b0;
        model_reset();
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        in_valid = 1'b0;

        // Same-cycle write-back to x3 must be seen by the decoded add.
        drive(32'h000180B3, 32'h00000040, 32'd0, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("bypass_reg_a", out_reg_a, 32'hDEADBEEF);
        chk("bypass_reg_b", out_reg_b, 32'd0);
        tick();

        for (int i = 1; i < 9; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'h1000_0000 * i + 32'(i);
            tick();
        end
        wb_en = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].inst, vecs[i].pc, vecs[i].imm, vecs[i].rw);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Load-use: two stalled cycles, accepted once the load leaves EX.
        s0 = m_cnt;
        drive(32'h00138133, 32'h00000500, 32'd0, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd7;
        tick();
        tick();
        chk("loaduse_stalls", 32'(stall_count), 32'(s0) + 32'd2);
        chk("loaduse_bubble", 32'(out_valid), 32'd0);
        ex_mem_read = 1'b0;
        tick();
        chk("loaduse_accepted", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();

        // Backpressure holds outputs, then flush discards the held instruction.
        drive(vecs[1].inst, 32'h00000600, vecs[1].imm, vecs[1].rw);
        tick();
        out_ready = 1'b0;
        drive(vecs[6].inst, 32'h00000604, vecs[6].imm, vecs[6].rw);
        tick();
        tick();
        tick();
        chk("bp_hold_pc", out_pc, 32'h00000600);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Flush together with a hazard: flush wins, no stall counted.
        s0 = m_cnt;
        drive(32'h00138133, 32'h00000700, 32'd0, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd7; flush = 1'b1;
        tick();
        chk("flush_hazard_nocount", 32'(stall_count), 32'(s0));
        flush = 1'b0; ex_mem_read = 1'b0; in_valid = 1'b0;
        tick();

        // Asynchronous reset while an instruction is held on the output.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h00000055;
        tick();
        wb_en = 1'b0;
        drive(vecs[8].inst, 32'h00000800, vecs[8].imm, vecs[8].rw);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        model_reset();
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_stall", 32'(stall_count), 32'd0);
        chk("midreset_out_pc", out_pc, 32'd0);
        chk("midreset_reg_a", out_reg_a, 32'd0);
        in_valid = 1'b1;
        tick();
        reset = 1'b1; out_ready = 1'b1;
        drive(vecs[8].inst, 32'h00000900, vecs[8].imm, vecs[8].rw);
        tick();
        in_valid = 1'b0;
        chk("x5_after_reset", out_reg_a, 32'd0);
        tick();

        // Saturate the stall counter, then check that x0 ignores writes.
        drive(32'h00138133, 32'h00000A00, 32'd0, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd7;
        for (int i = 0; i < 70000; i++) tick();
        chk("stall_saturated", 32'(stall_count), 32'h0000FFFF);
        ex_mem_read = 1'b0;
        drive(32'h000000B3, 32'h00000A04, 32'd0, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd5;
        tick();
        wb_en = 1'b0;
        chk("x0_bypass_blocked", out_reg_a, 32'd0);
        tick();
        chk("x0_write_dropped", out_reg_b, 32'd0);
        in_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
